instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction fields into words and writes them to instruction memory
// Optional feature macro: INSTR_ENC_CHECKSUM_EN adds a running XOR checksum output.
module instr_encoder #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     in_kind,
    input  logic [4:0]                     in_rs,
    input  logic [4:0]                     in_rt,
    input  logic [4:0]                     in_rd,
    input  logic [5:0]                     in_funct,
    input  logic [15:0]                    in_imm,
    input  logic [25:0]                    in_target,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           err
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [31:0]                    checksum
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    // Keeps in_ready low until the first clock edge after reset release.
    logic            live_q;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0]     ck_q, ck_d;
`endif

    logic [31:0]     enc_word;
    logic            kind_legal;
    logic            accept;
    logic            do_write;

    always_comb begin
        enc_word   = 32'h0;
        kind_legal = 1'b1;
        case (in_kind)
            3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            3'd4:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            3'd5:    enc_word = {6'b000010, in_target};
            default: kind_legal = 1'b0;
        endcase
    end

    assign in_ready = live_q && (state_q != S_FULL) && !clear;
    assign accept   = in_valid && in_ready;
    assign do_write = accept && kind_legal;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef INSTR_ENC_CHECKSUM_EN
        ck_d    = ck_q;
`endif
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            err_d   = 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
            ck_d    = 32'h0;
`endif
        end else if (do_write) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            wdata_d = enc_word;
            count_d = count_q + 1'b1;
            state_d = (count_q == LAST_SLOT) ? S_FULL : S_FILL;
`ifdef INSTR_ENC_CHECKSUM_EN
            ck_d    = ck_q ^ enc_word;
`endif
        end else if (accept) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0;
            live_q  <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
            ck_q    <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            live_q  <= 1'b1;
`ifdef INSTR_ENC_CHECKSUM_EN
            ck_q    <= ck_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign full      = (state_q == S_FULL);
    assign err       = err_q;
`ifdef INSTR_ENC_CHECKSUM_EN
    assign checksum  = ck_q;
`endif

endmodule
